qoi_dma: RTL and testbench
==========================

Name: qoi_dma

Overview:
- Bus-master DMA controller that moves byte blocks between 65C02 system memory and the QOI accelerator's 1 KiB buffer port.
- Programmed through an 8-byte register window; the CPU is halted via RDY for the whole transfer.
- Sits beside the CPU on the address map. While `dma_active` is high, the top-level bus mux routes system memory and the accelerator buffer port to this block instead of the CPU.

Parameters:
- SYS_AW, 16, system address width.
- BUF_AW, 10, accelerator buffer address width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- cs  in  1  register window select
- we  in  1  CPU write strobe
- addr  in  3  register index
- data_i  in  8  CPU write data
- data_o  out  8  register read data, combinational from addr
- cpu_rdy  out  1  to CPU RDY; 0 halts CPU
- dma_active  out  1  bus mux select (1 = DMA owns memory and buffer ports)
- m_addr  out  SYS_AW  system memory address
- m_rd  out  1  system read request; data returned on m_rdata one cycle later
- m_we  out  1  system write strobe
- m_wdata  out  8  system write data
- m_rdata  in  8  system read data
- a_cs  out  1  accelerator buffer select
- a_addr  out  BUF_AW  buffer address
- a_we  out  1  buffer write strobe
- a_wdata  out  8  buffer write data
- a_rdata  in  8  buffer read data, one-cycle latency
- irq  out  1  completion interrupt, level, active-high

Behaviour:
Registers (writes take effect at posedge when cs&we):
- 0 SYS_LO, 1 SYS_HI: live system address.
- 2 BUF_LO, 3 BUF_HI[1:0]: live buffer address; BUF_HI[7:2] reads 0.
- 4 LEN_LO, 5 LEN_HI: live remaining byte count.
- 6 CTRL.
  - Write: bit0 START, bit1 DIR (0 = sys->buf, 1 = buf->sys), bit2 IRQ_EN.
  - Read: bit0 BUSY, bit1 DIR, bit2 IRQ_EN, bit7 DONE, others 0.
- 7 CLEAR: any write clears DONE and irq. Reads 0.

Register write rules:
- Register writes while BUSY are ignored. This is unreachable in normal use because the CPU is halted.
- START is self-clearing and never stored.

Reset:
- All registers 0, state IDLE.
- cpu_rdy=1, dma_active=0, irq=0.
- All m_*/a_* strobes 0; addresses and data 0.

FSM states: IDLE, STALL, RD, WR, DONE.
- IDLE, START written with LEN!=0: state -> STALL, BUSY=1, DONE=0, cpu_rdy=0 from the next cycle.
- IDLE, START written with LEN==0: stay IDLE, DONE=1, irq=IRQ_EN. No stall.
- STALL: one settling cycle. Outputs idle, dma_active=1. Next state RD.
- RD (dma_active=1):
  - DIR=0: m_addr=SYS, m_rd=1.
  - DIR=1: a_cs=1, a_addr=BUF, a_we=0.
  - Next state WR.
- WR (dma_active=1):
  - DIR=0: a_cs=1, a_we=1, a_addr=BUF, a_wdata=m_rdata.
  - DIR=1: m_we=1, m_addr=SYS, m_wdata=a_rdata.
  - At the closing posedge: SYS+=1 (wraps mod 2^16), BUF+=1 (wraps mod 2^10), LEN-=1.
  - Next state DONE if LEN was 1, else RD.
- DONE: dma_active=0, BUSY=0, DONE=1, irq=IRQ_EN, cpu_rdy=1. Next state IDLE.

Timing and status:
- Throughput is 1 byte per 2 cycles.
- Total CPU stall for N bytes is 2N+2 cycles.
- irq holds until a CLEAR write or the next START.
- All m_*/a_* outputs are 0 whenever dma_active=0.

Boundary conditions:
- LEN=0xFFFF: legal; runs to completion.
- BUF wrap 0x3FF->0x000 and SYS wrap 0xFFFF->0x0000: silent.
- DIR, IRQ_EN changed mid-transfer: impossible (writes ignored).
- Async rst mid-transfer: immediately returns to reset values, cpu_rdy=1. A partial transfer is not resumed.
- CLEAR and START in the same cycle: impossible (distinct addresses). START while DONE=1 clears DONE.

Test Plan:
- Reset mid-flight: after reset, read all registers -> 0. cpu_rdy=1, irq=0, no m_*/a_* activity.
- Forward copy: SYS=0x8000, BUF=0x000, LEN=4, DIR=0, IRQ_EN=1; START; system bytes 11,22,33,44.
  - Expect buffer[0..3]=11,22,33,44.
  - cpu_rdy low exactly 10 cycles, then irq=1.
  - Afterwards SYS=0x8004, BUF=0x004, LEN=0, DONE=1.
- Reverse copy with buffer wrap: BUF=0x3FE, SYS=0x9000, LEN=3, DIR=1; buffer[0x3FE,0x3FF,0x000]=A1,B2,C3.
  - Expect system 0x9000..0x9002=A1,B2,C3 and final BUF=0x001.
  - irq stays 0 (IRQ_EN=0).
- LEN=0 start with IRQ_EN=1 -> cpu_rdy never drops, no bus strobes, DONE=1 and irq=1 the next cycle. CLEAR write -> DONE=0, irq=0.
- Async rst asserted during RD of byte 2 of an 8-byte transfer -> cpu_rdy=1 and dma_active=0 immediately, registers 0, buffer holds only byte 0.
- Stall behaviour: CPU bus-interface model issues a register write during BUSY -> ignored. System SYS/BUF counter wrap from 0xFFFF with LEN=2 -> bytes at 0xFFFF and 0x0000 transferred.

Source files
------------

// File: rtl/qoi_dma.sv
// Byte-block DMA between 65C02 system memory and the QOI accelerator buffer.
// The CPU is held off via RDY from START until the transfer has completed.
module qoi_dma #(
  parameter int SYS_AW = 16,
  parameter int BUF_AW = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              we,
  input  logic [2:0]        addr,
  input  logic [7:0]        data_i,
  output logic [7:0]        data_o,
  output logic              cpu_rdy,
  output logic              dma_active,
  output logic [SYS_AW-1:0] m_addr,
  output logic              m_rd,
  output logic              m_we,
  output logic [7:0]        m_wdata,
  input  logic [7:0]        m_rdata,
  output logic              a_cs,
  output logic [BUF_AW-1:0] a_addr,
  output logic              a_we,
  output logic [7:0]        a_wdata,
  input  logic [7:0]        a_rdata,
  output logic              irq
);

  typedef enum logic [2:0] {S_IDLE, S_STALL, S_RD, S_WR, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [SYS_AW-1:0]   r_sys;
  logic [BUF_AW-1:0]   r_buf;
  logic [15:0]         r_len;
  logic                r_dir;
  logic                r_irq_en;
  logic                r_done;
  logic                r_irq;

  logic                w_busy;
  logic                w_wr;
  logic                w_start;
  logic [15:0]         w_sys16;
  logic [15:0]         w_buf16;

  assign w_busy  = (r_state != S_IDLE);
  assign w_wr    = cs & we & ~w_busy;
  assign w_start = w_wr & (addr == 3'd6) & data_i[0];
  assign w_sys16 = 16'(r_sys);
  assign w_buf16 = 16'(r_buf);

  assign cpu_rdy = ~w_busy;
  assign irq     = r_irq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Register window, address/count stepping and completion status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sys    <= '0;
      r_buf    <= '0;
      r_len    <= '0;
      r_dir    <= 1'b0;
      r_irq_en <= 1'b0;
      r_done   <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr) begin
        case (addr)
          3'd0: r_sys <= SYS_AW'({w_sys16[15:8], data_i});
          3'd1: r_sys <= SYS_AW'({data_i, w_sys16[7:0]});
          3'd2: r_buf <= BUF_AW'({w_buf16[15:8], data_i});
          3'd3: r_buf <= BUF_AW'({data_i, w_buf16[7:0]});
          3'd4: r_len <= {r_len[15:8], data_i};
          3'd5: r_len <= {data_i, r_len[7:0]};
          3'd6: begin
            r_dir    <= data_i[1];
            r_irq_en <= data_i[2];
            // A zero-length START completes at once; otherwise it clears status.
            if (data_i[0]) begin
              r_done <= (r_len == 16'd0);
              r_irq  <= (r_len == 16'd0) & data_i[2];
            end
          end
          default: begin
            r_done <= 1'b0;
            r_irq  <= 1'b0;
          end
        endcase
      end
      if (r_state == S_WR) begin
        r_sys <= r_sys + SYS_AW'(1);
        r_buf <= r_buf + BUF_AW'(1);
        r_len <= r_len - 16'd1;
      end
      if (r_state == S_DONE) begin
        r_done <= 1'b1;
        r_irq  <= r_irq_en;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    dma_active = 1'b0;
    m_addr     = '0;
    m_rd       = 1'b0;
    m_we       = 1'b0;
    m_wdata    = 8'h00;
    a_cs       = 1'b0;
    a_addr     = '0;
    a_we       = 1'b0;
    a_wdata    = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (w_start && (r_len != 16'd0)) w_next = S_STALL;
      end
      S_STALL: begin
        dma_active = 1'b1;
        w_next     = S_RD;
      end
      S_RD: begin
        dma_active = 1'b1;
        if (!r_dir) begin
          m_addr = r_sys;
          m_rd   = 1'b1;
        end else begin
          a_cs   = 1'b1;
          a_addr = r_buf;
        end
        w_next = S_WR;
      end
      S_WR: begin
        dma_active = 1'b1;
        if (!r_dir) begin
          a_cs    = 1'b1;
          a_we    = 1'b1;
          a_addr  = r_buf;
          a_wdata = m_rdata;
        end else begin
          m_we    = 1'b1;
          m_addr  = r_sys;
          m_wdata = a_rdata;
        end
        w_next = (r_len == 16'd1) ? S_DONE : S_RD;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    data_o = 8'h00;
    case (addr)
      3'd0: data_o = w_sys16[7:0];
      3'd1: data_o = w_sys16[15:8];
      3'd2: data_o = w_buf16[7:0];
      3'd3: data_o = w_buf16[15:8];
      3'd4: data_o = r_len[7:0];
      3'd5: data_o = r_len[15:8];
      3'd6: data_o = {r_done, 4'b0000, r_irq_en, r_dir, w_busy};
      default: data_o = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_qoi_dma.sv
// Bench for qoi_dma: memory models, CPU register access and a bus-write scoreboard.
module tb_qoi_dma;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs, we;
  logic [2:0]  addr;
  logic [7:0]  data_i, data_o;
  logic        cpu_rdy, dma_active;
  logic [15:0] m_addr;
  logic        m_rd, m_we;
  logic [7:0]  m_wdata, m_rdata;
  logic        a_cs;
  logic [9:0]  a_addr;
  logic        a_we;
  logic [7:0]  a_wdata, a_rdata;
  logic        irq;

  qoi_dma #(.SYS_AW(16), .BUF_AW(10)) dut (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .addr(addr), .data_i(data_i),
    .data_o(data_o), .cpu_rdy(cpu_rdy), .dma_active(dma_active),
    .m_addr(m_addr), .m_rd(m_rd), .m_we(m_we), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .a_cs(a_cs), .a_addr(a_addr), .a_we(a_we), .a_wdata(a_wdata), .a_rdata(a_rdata),
    .irq(irq)
  );

  always #5 clk = ~clk;

  logic [7:0]  sys_mem [0:65535];
  logic [7:0]  buf_mem [0:1023];
  logic        pk_en = 1'b0, pk_sys = 1'b0;
  logic [15:0] pk_a = 16'h0;
  logic [7:0]  pk_d = 8'h0;

  always @(posedge clk) begin
    if (pk_en) begin
      if (pk_sys) sys_mem[pk_a] <= pk_d;
      else        buf_mem[pk_a[9:0]] <= pk_d;
    end
    if (m_rd) m_rdata <= sys_mem[m_addr];
    if (m_we) sys_mem[m_addr] <= m_wdata;
    if (a_cs && !a_we) a_rdata <= buf_mem[a_addr];
    if (a_cs && a_we) buf_mem[a_addr] <= a_wdata;
  end

  int checks = 0;
  int errors = 0;
  logic [24:0] sb [$];
  int idle_err = 0, strobe_cnt = 0, rdy_low_cnt = 0, wr_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus monitor: every memory/buffer write is matched against the scoreboard.
  always @(negedge clk) begin
    logic [24:0] got;
    if (!rst) begin
      if (!dma_active && (m_rd || m_we || a_cs || a_we || m_addr != 16'h0 || a_addr != 10'h0 ||
                          m_wdata != 8'h0 || a_wdata != 8'h0))
        idle_err <= idle_err + 1;
      if (m_rd || m_we || a_cs) strobe_cnt <= strobe_cnt + 1;
      if (!cpu_rdy) rdy_low_cnt <= rdy_low_cnt + 1;
      if ((a_cs && a_we) || m_we) begin
        wr_cnt <= wr_cnt + 1;
        got = m_we ? {1'b1, m_addr, m_wdata} : {1'b0, 6'b0, a_addr, a_wdata};
        if (sb.size() == 0) check("bus_wr_unexpected", sb.size(), 1);
        else check("bus_wr", got, sb.pop_front());
      end
    end
  end

  task automatic poke(input logic is_sys, input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    pk_en = 1'b1; pk_sys = is_sys; pk_a = a; pk_d = d;
    @(negedge clk);
    pk_en = 1'b0;
  endtask

  task automatic reg_wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; addr = a; data_i = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0; data_i = 8'h00;
  endtask

  task automatic reg_rd(input logic [2:0] a, output logic [7:0] d);
    addr = a;
    #1;
    d = data_o;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!cpu_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, cpu_rdy, 1'b1);
  endtask

  task automatic setup(input logic [15:0] s, input logic [9:0] b, input logic [15:0] l);
    reg_wr(3'd0, s[7:0]);
    reg_wr(3'd1, s[15:8]);
    reg_wr(3'd2, b[7:0]);
    reg_wr(3'd3, {6'b0, b[9:8]});
    reg_wr(3'd4, l[7:0]);
    reg_wr(3'd5, l[15:8]);
  endtask

  initial begin
    logic [7:0] d;
    int n, s0, r0, w0;
    rst = 1'b1; cs = 1'b0; we = 1'b0; addr = 3'd0; data_i = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_cpu_rdy", cpu_rdy, 1'b1);
    check("rst_dma_active", dma_active, 1'b0);
    check("rst_irq", irq, 1'b0);
    check("rst_bus", {m_rd, m_we, a_cs, a_we, m_addr, a_addr}, 0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      reg_rd(3'(i), d);
      check($sformatf("rst_reg%0d", i), d, 8'h00);
    end

    // Forward copy sys->buf with IRQ
    poke(1'b1, 16'h8000, 8'h11); poke(1'b1, 16'h8001, 8'h22);
    poke(1'b1, 16'h8002, 8'h33); poke(1'b1, 16'h8003, 8'h44);
    setup(16'h8000, 10'h000, 16'd4);
    sb.push_back({1'b0, 16'h0000, 8'h11}); sb.push_back({1'b0, 16'h0001, 8'h22});
    sb.push_back({1'b0, 16'h0002, 8'h33}); sb.push_back({1'b0, 16'h0003, 8'h44});
    reg_wr(3'd6, 8'h05);
    n = 0;
    while (!cpu_rdy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("fwd_stall_cycles", n, 10);
    check("fwd_irq", irq, 1'b1);
    reg_rd(3'd0, d); check("fwd_sys_lo", d, 8'h04);
    reg_rd(3'd1, d); check("fwd_sys_hi", d, 8'h80);
    reg_rd(3'd2, d); check("fwd_buf_lo", d, 8'h04);
    reg_rd(3'd3, d); check("fwd_buf_hi", d, 8'h00);
    reg_rd(3'd4, d); check("fwd_len_lo", d, 8'h00);
    reg_rd(3'd6, d); check("fwd_ctrl", d, 8'h84);
    check("fwd_mem", {buf_mem[0], buf_mem[1], buf_mem[2], buf_mem[3]}, 32'h11223344);

    // Reverse copy buf->sys across the buffer wrap, no IRQ
    poke(1'b0, 16'h03FE, 8'hA1); poke(1'b0, 16'h03FF, 8'hB2); poke(1'b0, 16'h0000, 8'hC3);
    setup(16'h9000, 10'h3FE, 16'd3);
    sb.push_back({1'b1, 16'h9000, 8'hA1}); sb.push_back({1'b1, 16'h9001, 8'hB2});
    sb.push_back({1'b1, 16'h9002, 8'hC3});
    reg_wr(3'd6, 8'h03);
    wait_done("rev_done");
    check("rev_irq", irq, 1'b0);
    reg_rd(3'd2, d); check("rev_buf_lo", d, 8'h01);
    reg_rd(3'd3, d); check("rev_buf_hi", d, 8'h00);
    reg_rd(3'd0, d); check("rev_sys_lo", d, 8'h03);
    reg_rd(3'd6, d); check("rev_ctrl", d, 8'h82);
    check("rev_mem", {sys_mem[16'h9000], sys_mem[16'h9001], sys_mem[16'h9002]}, 24'hA1B2C3);

    // Zero-length START, then CLEAR
    s0 = strobe_cnt; r0 = rdy_low_cnt;
    reg_wr(3'd6, 8'h05);
    check("len0_irq", irq, 1'b1);
    check("len0_rdy", cpu_rdy, 1'b1);
    reg_rd(3'd6, d); check("len0_ctrl", d, 8'h84);
    repeat (3) @(negedge clk);
    check("len0_no_strobes", strobe_cnt - s0, 0);
    check("len0_no_stall", rdy_low_cnt - r0, 0);
    reg_wr(3'd7, 8'hFF);
    check("clear_irq", irq, 1'b0);
    reg_rd(3'd6, d); check("clear_ctrl", d, 8'h04);
    reg_rd(3'd7, d); check("clear_read", d, 8'h00);

    // Async reset during the read of the second byte of an 8-byte transfer
    for (int i = 0; i < 8; i++) begin
      poke(1'b1, 16'hA000 + 16'(i), 8'h60 + 8'(i));
      poke(1'b0, 16'h0010 + 16'(i), 8'hEE);
      sb.push_back({1'b0, 16'h0010 + 16'(i), 8'h60 + 8'(i)});
    end
    setup(16'hA000, 10'h010, 16'd8);
    w0 = wr_cnt;
    reg_wr(3'd6, 8'h05);
    n = 0;
    while (!(m_rd && m_addr == 16'hA001) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rstmid_reached_rd", (m_rd && m_addr == 16'hA001), 1'b1);
    #1 rst = 1'b1;
    #1;
    check("rstmid_cpu_rdy", cpu_rdy, 1'b1);
    check("rstmid_dma_active", dma_active, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      reg_rd(3'(i), d);
      check($sformatf("rstmid_reg%0d", i), d, 8'h00);
    end
    check("rstmid_irq", irq, 1'b0);
    check("rstmid_wr_count", wr_cnt - w0, 1);
    check("rstmid_buf", {buf_mem[10'h010], buf_mem[10'h011]}, 16'h60EE);
    check("rstmid_sb_left", sb.size(), 7);
    sb.delete();

    // Address wrap at 0xFFFF with ignored writes while busy
    poke(1'b1, 16'hFFFF, 8'h5A); poke(1'b1, 16'h0000, 8'hA5);
    setup(16'hFFFF, 10'h200, 16'd2);
    sb.push_back({1'b0, 16'h0200, 8'h5A}); sb.push_back({1'b0, 16'h0201, 8'hA5});
    reg_wr(3'd6, 8'h01);
    reg_wr(3'd0, 8'h12);
    reg_wr(3'd6, 8'h06);
    wait_done("wrap_done");
    reg_rd(3'd0, d); check("wrap_sys_lo", d, 8'h01);
    reg_rd(3'd1, d); check("wrap_sys_hi", d, 8'h00);
    reg_rd(3'd2, d); check("wrap_buf_lo", d, 8'h02);
    reg_rd(3'd3, d); check("wrap_buf_hi", d, 8'h02);
    reg_rd(3'd6, d); check("wrap_ctrl", d, 8'h80);
    check("wrap_mem", {buf_mem[10'h200], buf_mem[10'h201]}, 16'h5AA5);

    repeat (2) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    check("idle_bus_quiet", idle_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
